// File: rtl/ppt_gate_driver_pkg.sv
// Shared definitions for the PPT gate driver: state encodings and default sizing.
// The fault path is compiled in only when PPT_GATE_FAULT_EN is defined.
package ppt_gate_driver_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LO      = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HI      = 3'd3,
    ST_DT_FALL = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam int DEF_DT_W   = 6;
  localparam int DEF_MIN_ON = 2;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/ppt_gate_driver_if.sv
// Control and status bundle between the pulse generator side and the gate driver.
interface ppt_gate_driver_if
  import ppt_gate_driver_pkg::*;
#(
    parameter int DT_W  = DEF_DT_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             en;
    logic             pulse_in;
    logic [DT_W-1:0]  dead_time;
    logic             fault_n;
    logic             fault_clr;
    logic             gate_hi;
    logic             gate_lo;
    logic [CNT_W-1:0] fire_count;
    logic             fault_latched;
    logic             busy;

    modport master (
        output en, pulse_in, dead_time, fault_n, fault_clr,
        input  gate_hi, gate_lo, fire_count, fault_latched, busy
    );

    modport slave (
        input  en, pulse_in, dead_time, fault_n, fault_clr,
        output gate_hi, gate_lo, fire_count, fault_latched, busy
    );
endinterface

// File: rtl/ppt_gate_driver_sync_2ff.sv
// Generic two-flop synchronizer with a parameterised reset value.
// Shared by the fault input and the SCL/SDA conditioning paths.
module sync_2ff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn_int,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    // NOTE: flops use non-blocking assignments so meta->q shifts one stage per edge.
    always_ff @(posedge clk or negedge rstn_int) begin
        if (!rstn_int) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ppt_gate_driver.sv
// Complementary non-overlapping gate drive with dead time, minimum on-time and fire counting.
// Define PPT_GATE_FAULT_EN to build the synchronised, latched external fault path.
module ppt_gate_driver
  import ppt_gate_driver_pkg::*;
#(
    parameter int DT_W   = DEF_DT_W,
    parameter int MIN_ON = DEF_MIN_ON,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rstn_int,
    ppt_gate_driver_if.slave   bus
);
    localparam int             ON_W    = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
    localparam logic [ON_W-1:0] ON_LOAD = ON_W'(MIN_ON - 1);

    state_t           state, next_state;
    logic [DT_W-1:0]  dt_cnt, dt_cnt_d, dt_load;
    logic [ON_W-1:0]  on_cnt, on_cnt_d;
    logic             fire_evt;
    logic             gate_hi_q, gate_lo_q, busy_q;
    logic [CNT_W-1:0] fire_q;

`ifdef PPT_GATE_FAULT_EN
    logic fault_s;
    logic fault_q;

    sync_2ff #(.W(1), .RST_VAL(1'b1)) u_fault_sync (
        .clk      (clk),
        .rstn_int (rstn_int),
        .d        (bus.fault_n),
        .q        (fault_s)
    );
`else
    logic unused_fault;
    assign unused_fault = bus.fault_n ^ bus.fault_clr;
`endif

    // Counters hold "cycles remaining minus one", so a zero dead_time still gives one cycle.
    assign dt_load = (bus.dead_time == '0) ? '0 : bus.dead_time - DT_W'(1);

    always_ff @(posedge clk or negedge rstn_int) begin
        if (!rstn_int) begin
            state  <= ST_OFF;
            dt_cnt <= '0;
            on_cnt <= '0;
        end else begin
            state  <= next_state;
            dt_cnt <= dt_cnt_d;
            on_cnt <= on_cnt_d;
        end
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        next_state = state;
        dt_cnt_d   = dt_cnt;
        on_cnt_d   = on_cnt;
        fire_evt   = 1'b0;

        case (state)
            ST_OFF: begin
                if (bus.en && !bus.pulse_in) next_state = ST_LO;
            end
            ST_LO: begin
                if (!bus.en) begin
                    next_state = ST_OFF;
                end else if (bus.pulse_in) begin
                    next_state = ST_DT_RISE;
                    dt_cnt_d   = dt_load;
                end
            end
            ST_DT_RISE: begin
                if (!bus.en) begin
                    next_state = ST_OFF;
                end else if (!bus.pulse_in) begin
                    next_state = ST_LO;
                end else if (dt_cnt == '0) begin
                    next_state = ST_HI;
                    on_cnt_d   = ON_LOAD;
                end else begin
                    dt_cnt_d = dt_cnt - DT_W'(1);
                end
            end
            ST_HI: begin
                if (on_cnt != '0) begin
                    on_cnt_d = on_cnt - ON_W'(1);
                end else if (!bus.pulse_in || !bus.en) begin
                    next_state = ST_DT_FALL;
                    dt_cnt_d   = dt_load;
                    fire_evt   = 1'b1;
                end
            end
            ST_DT_FALL: begin
                if (dt_cnt == '0) begin
                    next_state = bus.en ? ST_LO : ST_OFF;
                end else begin
                    dt_cnt_d = dt_cnt - DT_W'(1);
                end
            end
            ST_FAULT: begin
`ifdef PPT_GATE_FAULT_EN
                if (bus.fault_clr && fault_s && !bus.pulse_in) next_state = ST_OFF;
`else
                next_state = ST_OFF;
`endif
            end
            default: next_state = ST_OFF;
        endcase

`ifdef PPT_GATE_FAULT_EN
        // A present fault overrides everything, including the fire count of an aborted HI.
        if (!fault_s) begin
            next_state = ST_FAULT;
            fire_evt   = 1'b0;
        end
`endif
    end

    // Gate outputs are one-hot decodes of a single state, so they can never overlap.
    always_ff @(posedge clk or negedge rstn_int) begin
        if (!rstn_int) begin
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            busy_q    <= 1'b0;
            fire_q    <= '0;
        end else begin
            gate_hi_q <= (next_state == ST_HI);
            gate_lo_q <= (next_state == ST_LO);
            busy_q    <= (next_state inside {ST_DT_RISE, ST_HI, ST_DT_FALL});
            if (fire_evt && (fire_q != '1)) fire_q <= fire_q + CNT_W'(1);
        end
    end

`ifdef PPT_GATE_FAULT_EN
    always_ff @(posedge clk or negedge rstn_int) begin
        if (!rstn_int) fault_q <= 1'b0;
        else           fault_q <= (next_state == ST_FAULT);
    end
    assign bus.fault_latched = fault_q;
`else
    assign bus.fault_latched = 1'b0;
`endif

    assign bus.gate_hi    = gate_hi_q;
    assign bus.gate_lo    = gate_lo_q;
    assign bus.busy       = busy_q;
    assign bus.fire_count = fire_q;

endmodule

// File: tb/tb_ppt_gate_driver.sv
// Directed self-checking bench for ppt_gate_driver (MIN_ON=2 main instance, MIN_ON=4 second instance).
module tb_ppt_gate_driver;
    import ppt_gate_driver_pkg::*;

`ifdef PPT_GATE_FAULT_EN
    localparam int CNT_AFTER_FAULT = 1;
`else
    localparam int CNT_AFTER_FAULT = 2;
`endif

    logic clk      = 1'b0;
    logic rstn_int = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic overlap  = 1'b0;
    logic [3:0] obs;
    logic [3:0] exp_v;

    ppt_gate_driver_if #(.DT_W(6), .CNT_W(8)) bus  ();
    ppt_gate_driver_if #(.DT_W(6), .CNT_W(8)) bus4 ();

    ppt_gate_driver #(.DT_W(6), .MIN_ON(2), .CNT_W(8)) u_dut (
        .clk(clk), .rstn_int(rstn_int), .bus(bus)
    );
    ppt_gate_driver #(.DT_W(6), .MIN_ON(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rstn_int(rstn_int), .bus(bus4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((bus.gate_hi & bus.gate_lo) === 1'b1 || (bus4.gate_hi & bus4.gate_lo) === 1'b1)
            overlap = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // obs packs {gate_hi, gate_lo, busy, fault_latched}
    task automatic test_reset();
        bus.en = 1'b0;  bus.pulse_in = 1'b0;  bus.dead_time = '0;  bus.fault_n = 1'b1;  bus.fault_clr = 1'b0;
        bus4.en = 1'b0; bus4.pulse_in = 1'b0; bus4.dead_time = '0; bus4.fault_n = 1'b1; bus4.fault_clr = 1'b0;
        rstn_int = 1'b0;
        #12;
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if ({obs, bus.fire_count} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 000", {obs, bus.fire_count});
        end
        n_checks++;
        if ({bus4.gate_hi, bus4.gate_lo, bus4.fire_count} !== 10'h000) begin
            n_fail++; $display("FAIL reset_outputs4: got %h want 000", {bus4.gate_hi, bus4.gate_lo, bus4.fire_count});
        end
        @(negedge clk);
        rstn_int = 1'b1;
        step(2);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++; $display("FAIL off_while_disabled: got %b want 0000", obs);
        end
    endtask

    task automatic test_basic();
        bus.dead_time = 6'd3;
        bus.en        = 1'b1;
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0100) begin
            n_fail++; $display("FAIL basic_enter_lo: got %b want 0100", obs);
        end
        for (int i = 0; i < 15; i++) begin
            bus.pulse_in = (i < 10);
            step(1);
            exp_v = {(i >= 3 && i <= 9), (i >= 13), (i <= 12), 1'b0};
            obs   = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL basic_cycle[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
        n_checks++;
        if (bus.fire_count !== 8'd1) begin
            n_fail++; $display("FAIL basic_fire_count: got %0d want 1", bus.fire_count);
        end
    endtask

    task automatic test_abort();
        bus.dead_time = 6'd0;
        for (int i = 0; i < 4; i++) begin
            bus.pulse_in = (i == 0);
            step(1);
            exp_v = {1'b0, (i >= 1), (i == 0), 1'b0};
            obs   = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL abort_cycle[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
        n_checks++;
        if (bus.fire_count !== 8'd1) begin
            n_fail++; $display("FAIL abort_fire_count: got %0d want 1", bus.fire_count);
        end
    endtask

    task automatic test_min_on();
        bus4.dead_time = 6'd1;
        bus4.en        = 1'b1;
        step(1);
        n_checks++;
        if (bus4.gate_lo !== 1'b1) begin
            n_fail++; $display("FAIL min_on_enter_lo: got %b want 1", bus4.gate_lo);
        end
        for (int i = 0; i < 9; i++) begin
            bus4.pulse_in = (i < 2);
            step(1);
            exp_v = {(i >= 1 && i <= 4), (i >= 6), (i <= 5), 1'b0};
            obs   = {bus4.gate_hi, bus4.gate_lo, bus4.busy, bus4.fault_latched};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL min_on_cycle[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
        n_checks++;
        if (bus4.fire_count !== 8'd1) begin
            n_fail++; $display("FAIL min_on_fire_count: got %0d want 1", bus4.fire_count);
        end
        bus4.en = 1'b0;
    endtask

    task automatic test_fault();
        bus.dead_time = 6'd3;
        bus.pulse_in  = 1'b1;
        step(4);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b1010) begin
            n_fail++; $display("FAIL fault_reach_hi: got %b want 1010", obs);
        end
`ifdef PPT_GATE_FAULT_EN
        bus.fault_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (!bus.gate_hi && !bus.gate_lo) break;
        end
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0001) begin
            n_fail++; $display("FAIL fault_entry_3cyc: got %b want 0001", obs);
        end
        bus.pulse_in  = 1'b0;
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0001) begin
            n_fail++; $display("FAIL fault_clr_ignored: got %b want 0001", obs);
        end
        bus.fault_n = 1'b1;
        step(2);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0001) begin
            n_fail++; $display("FAIL fault_held_until_clr: got %b want 0001", obs);
        end
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++; $display("FAIL fault_clear_to_off: got %b want 0000", obs);
        end
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0100) begin
            n_fail++; $display("FAIL fault_off_to_lo: got %b want 0100", obs);
        end
`else
        bus.fault_n   = 1'b0;
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        step(3);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b1010) begin
            n_fail++; $display("FAIL fault_ignored_hi: got %b want 1010", obs);
        end
        bus.fault_n  = 1'b1;
        bus.pulse_in = 1'b0;
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0010) begin
            n_fail++; $display("FAIL fault_ignored_fall: got %b want 0010", obs);
        end
        step(3);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0100) begin
            n_fail++; $display("FAIL fault_ignored_lo: got %b want 0100", obs);
        end
`endif
        n_checks++;
        if (bus.fire_count !== 8'(CNT_AFTER_FAULT)) begin
            n_fail++; $display("FAIL fault_fire_count: got %0d want %0d", bus.fire_count, CNT_AFTER_FAULT);
        end
    endtask

    task automatic test_en_drop_reset();
        bus.pulse_in = 1'b1;
        step(4);
        bus.en = 1'b0;
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b1010) begin
            n_fail++; $display("FAIL en_drop_min_on: got %b want 1010", obs);
        end
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0010 || bus.fire_count !== 8'(CNT_AFTER_FAULT + 1)) begin
            n_fail++; $display("FAIL en_drop_dt_fall: got %b/%0d want 0010/%0d", obs, bus.fire_count, CNT_AFTER_FAULT + 1);
        end
        step(2);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0010) begin
            n_fail++; $display("FAIL en_drop_dt_hold: got %b want 0010", obs);
        end
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++; $display("FAIL en_drop_off: got %b want 0000", obs);
        end
        bus.pulse_in = 1'b0;
        bus.en       = 1'b1;
        step(1);
        bus.pulse_in = 1'b1;
        step(4);
        bus.pulse_in = 1'b0;
        step(2);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0010) begin
            n_fail++; $display("FAIL rst_pre_dt_fall: got %b want 0010", obs);
        end
        #2 rstn_int = 1'b0;
        #1;
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if ({obs, bus.fire_count} !== 12'h000) begin
            n_fail++; $display("FAIL async_reset_mid_dt: got %h want 000", {obs, bus.fire_count});
        end
        @(negedge clk);
        rstn_int = 1'b1;
        bus.en   = 1'b0;
        step(1);
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++; $display("FAIL restart_off: got %b want 0000", obs);
        end
    endtask

    task automatic test_saturation();
        bus.dead_time = 6'd0;
        bus.en        = 1'b1;
        step(1);
        for (int p = 0; p < 254; p++) begin
            bus.pulse_in = 1'b1; step(2);
            bus.pulse_in = 1'b0; step(3);
        end
        n_checks++;
        if (bus.fire_count !== 8'd254) begin
            n_fail++; $display("FAIL sat_before: got %0d want 254", bus.fire_count);
        end
        for (int p = 0; p < 6; p++) begin
            bus.pulse_in = 1'b1; step(2);
            bus.pulse_in = 1'b0; step(3);
        end
        obs = {bus.gate_hi, bus.gate_lo, bus.busy, bus.fault_latched};
        n_checks++;
        if (bus.fire_count !== 8'd255 || obs !== 4'b0100) begin
            n_fail++; $display("FAIL sat_hold: got %0d/%b want 255/0100", bus.fire_count, obs);
        end
    endtask

    task automatic test_invariant();
        n_checks++;
        if (overlap !== 1'b0) begin
            n_fail++; $display("FAIL gate_overlap: got %b want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_min_on();
        test_fault();
        test_en_drop_reset();
        test_saturation();
        test_invariant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
